// File: rtl/arb_pkg.sv
// Shared types, sizes and the round-robin selection helper for the
// four-requester arbiter.
package arb_pkg;

    localparam int N_REQ = 4;
    localparam int IDX_W = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Walk from the farthest candidate back to ptr so the nearest set bit wins.
    function automatic pick_t rr_pick(input logic [IDX_W-1:0] ptr,
                                      input logic [N_REQ-1:0] req);
        pick_t            res;
        logic [IDX_W-1:0] cand;
        res.valid = 1'b0;
        res.idx   = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            cand      = ptr + IDX_W'(i);
            res.valid = res.valid | req[cand];
            res.idx   = req[cand] ? cand : res.idx;
        end
        return res;
    endfunction

endpackage

// File: rtl/decoder_2to4.sv
// 2-to-4 one-hot decoder with enable; output is all-zero when disabled.
import arb_pkg::*;

module decoder_2to4 (
    input  logic [IDX_W-1:0] idx,
    input  logic             en,
    output logic [N_REQ-1:0] y
);

    assign y = en ? (N_REQ'(1) << idx) : {N_REQ{1'b0}};

endmodule

// File: rtl/rr_arbiter4.sv
// Round-robin arbiter for one shared resource: a grant is held until done,
// request drop, or the hold limit, and the last owner becomes lowest priority.
import arb_pkg::*;

module rr_arbiter4 #(
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] gnt,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             busy,
    output logic             timeout
);

    localparam int               CNT_W    = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam bit               HOLD_EN  = (HOLD_MAX != 0);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(HOLD_MAX);
    localparam logic [CNT_W-1:0] CNT_LAST = HOLD_EN ? CNT_W'(HOLD_MAX - 1) : {CNT_W{1'b0}};

    state_t           state_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] gnt_idx_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             timeout_q;

    pick_t            pick_s;
    logic             own_req_s;
    logic             rel_hold_s;
    logic             release_s;
    logic             tmo_s;

    assign pick_s     = rr_pick(ptr_q, req);
    assign own_req_s  = req[gnt_idx_q];
    assign rel_hold_s = HOLD_EN && (cnt_q == CNT_LAST);
    assign release_s  = done || !own_req_s || rel_hold_s;
    // Timeout is flagged only when the hold limit alone forced the release.
    assign tmo_s      = rel_hold_s && !done && own_req_s;

    // Saturating hold counter next value.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_q == CNT_SAT) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Arbitration state machine with registered owner, pointer and timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            ptr_q     <= {IDX_W{1'b0}};
            gnt_idx_q <= {IDX_W{1'b0}};
            cnt_q     <= {CNT_W{1'b0}};
            timeout_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    timeout_q <= 1'b0;
                    if (pick_s.valid) begin
                        gnt_idx_q <= pick_s.idx;
                        cnt_q     <= {CNT_W{1'b0}};
                        state_q   <= BUSY;
                    end else begin
                        state_q   <= IDLE;
                    end
                end
                BUSY: begin
                    if (release_s) begin
                        state_q   <= IDLE;
                        ptr_q     <= gnt_idx_q + 2'd1;
                        cnt_q     <= {CNT_W{1'b0}};
                        timeout_q <= tmo_s;
                    end else begin
                        cnt_q     <= cnt_d;
                        timeout_q <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    timeout_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy    = (state_q == BUSY);
    assign gnt_idx = gnt_idx_q;
    assign timeout = timeout_q;

    decoder_2to4 u_dec (
        .idx (gnt_idx_q),
        .en  (busy),
        .y   (gnt)
    );

endmodule

// File: tb/tb_rr_arbiter4.sv
// Randomized and directed bench for rr_arbiter4 against an owner/queue-level
// behavioural model of the round-robin rules.
module tb_rr_arbiter4;

    localparam int H = 8;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] gnt_idx;
    logic       busy;
    logic       timeout;

    int n_pass  = 0;
    int n_total = 0;

    // Model: current owner (-1 when idle), last owner, rotation start,
    // cycles the grant has been held, and the pending timeout pulse.
    int m_owner;
    int m_last;
    int m_ptr;
    int m_held;
    bit m_tmo;

    rr_arbiter4 #(.HOLD_MAX(H)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 0;
        m_ptr   = 0;
        m_held  = 0;
        m_tmo   = 1'b0;
    endtask

    task automatic model_step(input logic [3:0] r, input logic d);
        m_tmo = 1'b0;
        if (m_owner < 0) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (r[c]) begin
                    m_owner = c;
                    m_last  = c;
                    m_held  = 0;
                    break;
                end
            end
        end else begin
            m_held++;
            if (d || !r[m_owner] || (H != 0 && m_held >= H)) begin
                m_tmo   = !d && r[m_owner];
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
            end
        end
    endtask

    task automatic compare_model();
        logic [3:0] eg;
        eg = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        check("gnt",     gnt,              eg);
        check("gnt_idx", {2'b00, gnt_idx}, 4'(m_last));
        check("busy",    {3'b000, busy},   {3'b000, (m_owner >= 0)});
        check("timeout", {3'b000, timeout}, {3'b000, m_tmo});
    endtask

    // One clock: model consumes the inputs seen at the edge, outputs are
    // compared on the following falling edge.
    task automatic tick();
        @(posedge clk);
        model_step(req, done);
        @(negedge clk);
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        model_reset();
        compare_model();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("reset_gnt",  gnt, 4'b0000);
        check("reset_busy", {3'b000, busy}, 4'b0000);
        rst = 1'b0;

        // Idle with no requests.
        for (int i = 0; i < 10; i++) tick();

        // Rotation with done in the second cycle of each grant.
        begin
            logic [3:0] seq [5];
            seq[0] = 4'b0001; seq[1] = 4'b0010; seq[2] = 4'b0100;
            seq[3] = 4'b1000; seq[4] = 4'b0001;
            req = 4'b1111;
            for (int g = 0; g < 5; g++) begin
                tick();
                check("rot_c1", gnt, seq[g]);
                tick();
                check("rot_c2", gnt, seq[g]);
                done = 1'b1;
                tick();
                check("rot_gap", gnt, 4'b0000);
                done = 1'b0;
            end
        end

        // Hold limit with a lone requester, then re-grant.
        do_reset();
        req = 4'b0100;
        tick();
        for (int i = 0; i < H; i++) begin
            check("hold_gnt", gnt, 4'b0100);
            tick();
        end
        check("tmo_gnt", gnt, 4'b0000);
        check("tmo_pulse", {3'b000, timeout}, 4'b0001);
        tick();
        check("regrant", gnt, 4'b0100);
        check("tmo_clear", {3'b000, timeout}, 4'b0000);

        // Asynchronous reset while busy, no clock edge needed.
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_gnt",  gnt, 4'b0000);
        check("async_idx",  {2'b00, gnt_idx}, 4'b0000);
        check("async_busy", {3'b000, busy}, 4'b0000);
        model_reset();
        @(negedge clk);
        rst = 1'b0;

        // Drop of owner request: 1001 gives 0 then 3.
        req = 4'b1001;
        tick();
        check("drop_first", gnt, 4'b0001);
        tick(); tick();
        req = 4'b1000;
        tick();
        check("drop_rel", gnt, 4'b0000);
        req = 4'b1001;
        tick();
        check("drop_next", gnt, 4'b1000);
        check("drop_idx", {2'b00, gnt_idx}, 4'b0011);

        // Non-owner pulse inside BUSY is not latched.
        do_reset();
        req = 4'b0010;
        tick();
        tick();
        req = 4'b0011;
        tick(); tick();
        req = 4'b0010;
        tick();
        check("nonowner", gnt, 4'b0010);
        done = 1'b1;
        tick();
        done = 1'b0;
        req  = 4'b0000;
        tick(); tick();
        check("nonowner_idle", gnt, 4'b0000);

        // done coincides with the hold-limit edge, then reset while 1000 owns.
        do_reset();
        req = 4'b1000;
        tick();
        for (int i = 0; i < H - 1; i++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        check("coinc_gnt", gnt, 4'b0000);
        check("coinc_tmo", {3'b000, timeout}, 4'b0000);
        tick();
        check("own3", gnt, 4'b1000);
        do_reset();
        req = 4'b1111;
        tick();
        check("after_rst", gnt, 4'b0001);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            done = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
